// File: rtl/dram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dram_ctrl_pkg
// Shared definitions for the DRAM command scheduler:
//   - sched_state_e : request FSM states (IDLE, REQ_REF, REQ_WR, REQ_RD)
//   - default refresh interval, postponement limit and debounce length
//   - width of the refresh-owed counter
//   - cnt_width()   : counter width helper that never returns zero
// -----------------------------------------------------------------------------
package dram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ_REF = 2'd1,
    REQ_WR  = 2'd2,
    REQ_RD  = 2'd3
  } sched_state_e;

  // 7.8 us refresh interval at 320 MHz
  localparam int TREFI_CYC_DEF    = 2496;
  // refreshes that may be owed before a refresh pre-empts everything
  localparam int MAX_POSTPONE_DEF = 8;
  // 10 ms of stable input at 320 MHz
  localparam int DB_CYC_DEF       = 3200000;
  // ref_owed width; MAX_POSTPONE must stay <= 15
  localparam int OWED_W           = 4;

  // Width of a counter that runs 0..n-1; a 1-value counter still gets 1 bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_sync_debounce.sv
// -----------------------------------------------------------------------------
// btn_sync_debounce
// Brings one raw board button into the clk domain and produces a single-cycle
// pulse on each 0->1 transition of its debounced level.
//
// Build option: DRAM_SCHED_DEBOUNCE_EN
//   defined   : the level only follows the synchronized input after it has
//               differed from the current level for DB_CYC consecutive cycles
//   undefined : the synchronizer output is the level (2-cycle input latency)
//
// Ports:
//   clk    in  1  controller clock
//   rst_n  in  1  asynchronous active-low reset
//   btn    in  1  raw asynchronous button
//   rise   out 1  one-cycle pulse on a rising debounced level
// -----------------------------------------------------------------------------
module btn_sync_debounce
  import dram_ctrl_pkg::*;
#(
  parameter int DB_CYC = DB_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic meta_r;
  logic sync_r;
  logic prev_r;
  logic level_s;

  // Two-flop synchronizer for the asynchronous button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= btn;
      sync_r <= meta_r;
    end
  end

`ifdef DRAM_SCHED_DEBOUNCE_EN
  localparam int              DB_W    = cnt_width(DB_CYC);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);

  logic [DB_W-1:0] db_cnt_r;
  logic            level_r;

  // Debounce: count while input and level disagree, flip on the last count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_r <= '0;
      level_r  <= 1'b0;
    end else if (sync_r != level_r) begin
      if (db_cnt_r == DB_LAST) begin
        level_r  <= sync_r;
        db_cnt_r <= '0;
      end else begin
        db_cnt_r <= db_cnt_r + DB_W'(1);
      end
    end else begin
      db_cnt_r <= '0;
    end
  end

  assign level_s = level_r;
`else
  assign level_s = sync_r;
`endif

  // Previous debounced level for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= level_s;
    end
  end

  assign rise = level_s & ~prev_r;

endmodule

// File: rtl/dram_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// dram_cmd_scheduler
// Turns the write/read buttons and a refresh-interval timer into one-hot,
// level-held command requests for the DRAM controller. Refreshes may be
// postponed up to MAX_POSTPONE intervals; at that limit a refresh wins over
// everything, otherwise writes beat reads beat owed refreshes.
//
// Build option: DRAM_SCHED_DEBOUNCE_EN enables the button debounce counters
// (see btn_sync_debounce); arbitration and handshake are the same either way.
//
// Ports:
//   clk           in  1  320 MHz controller clock
//   rst_n         in  1  asynchronous active-low reset
//   btn_write     in  1  raw write button
//   btn_read      in  1  raw read button
//   ctrl_ready    in  1  controller idle, may start a new command
//   cmd_ack       in  1  one-cycle accept pulse for the current request
//   wr_req        out 1  write request, held until acknowledged
//   rd_req        out 1  read request, held until acknowledged
//   ref_req       out 1  refresh request, held until acknowledged
//   ref_owed      out 4  refreshes currently owed
//   ref_overflow  out 1  sticky: an interval elapsed with the owed count full
// -----------------------------------------------------------------------------
module dram_cmd_scheduler
  import dram_ctrl_pkg::*;
#(
  parameter int TREFI_CYC    = TREFI_CYC_DEF,
  parameter int MAX_POSTPONE = MAX_POSTPONE_DEF,
  parameter int DB_CYC       = DB_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_write,
  input  logic              btn_read,
  input  logic              ctrl_ready,
  input  logic              cmd_ack,
  output logic              wr_req,
  output logic              rd_req,
  output logic              ref_req,
  output logic [OWED_W-1:0] ref_owed,
  output logic              ref_overflow
);

  localparam int                TMR_W    = cnt_width(TREFI_CYC);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TREFI_CYC - 1);
  localparam logic [OWED_W-1:0] OWED_MAX = OWED_W'(MAX_POSTPONE);

  logic              wr_rise_s;
  logic              rd_rise_s;
  logic [TMR_W-1:0]  tmr_r;
  logic              tick_s;
  sched_state_e      state_r;
  sched_state_e      pick_s;
  logic              wr_pend_r;
  logic              rd_pend_r;
  logic [OWED_W-1:0] owed_r;
  logic              ovf_r;
  logic              wr_req_r;
  logic              rd_req_r;
  logic              ref_req_r;
  logic              ack_ref_s;
  logic              ack_wr_s;
  logic              ack_rd_s;

  btn_sync_debounce #(.DB_CYC(DB_CYC)) u_wr_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_write),
    .rise  (wr_rise_s)
  );

  btn_sync_debounce #(.DB_CYC(DB_CYC)) u_rd_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_read),
    .rise  (rd_rise_s)
  );

  assign tick_s    = (tmr_r == TMR_LAST);
  assign ack_ref_s = cmd_ack && (state_r == REQ_REF);
  assign ack_wr_s  = cmd_ack && (state_r == REQ_WR);
  assign ack_rd_s  = cmd_ack && (state_r == REQ_RD);

  // Refresh interval timer; the wrap cycle is the refresh tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_r <= '0;
    end else if (tick_s) begin
      tmr_r <= '0;
    end else begin
      tmr_r <= tmr_r + TMR_W'(1);
    end
  end

  // Pending write/read flags; an edge while already pending is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend_r <= 1'b0;
      rd_pend_r <= 1'b0;
    end else begin
      if (ack_wr_s) begin
        wr_pend_r <= 1'b0;
      end else if (wr_rise_s) begin
        wr_pend_r <= 1'b1;
      end else begin
        wr_pend_r <= wr_pend_r;
      end
      if (ack_rd_s) begin
        rd_pend_r <= 1'b0;
      end else if (rd_rise_s) begin
        rd_pend_r <= 1'b1;
      end else begin
        rd_pend_r <= rd_pend_r;
      end
    end
  end

  // Owed-refresh credits; a tick and a refresh ack in one cycle cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owed_r <= '0;
      ovf_r  <= 1'b0;
    end else if (tick_s && !ack_ref_s) begin
      if (owed_r == OWED_MAX) begin
        ovf_r <= 1'b1;
      end else begin
        owed_r <= owed_r + OWED_W'(1);
      end
    end else if (ack_ref_s && !tick_s) begin
      owed_r <= owed_r - OWED_W'(1);
    end else begin
      owed_r <= owed_r;
    end
  end

  // Arbitration choice from IDLE. A button edge in this very cycle counts as
  // pending so the request appears one cycle after the edge.
  always_comb begin
    pick_s = IDLE;
    if (owed_r == OWED_MAX) begin
      pick_s = REQ_REF;
    end else if (wr_pend_r || wr_rise_s) begin
      pick_s = REQ_WR;
    end else if (rd_pend_r || rd_rise_s) begin
      pick_s = REQ_RD;
    end else if (owed_r != '0) begin
      pick_s = REQ_REF;
    end else begin
      pick_s = IDLE;
    end
  end

  // Request FSM with registered one-hot request outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      wr_req_r  <= 1'b0;
      rd_req_r  <= 1'b0;
      ref_req_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (ctrl_ready) begin
            state_r   <= pick_s;
            wr_req_r  <= (pick_s == REQ_WR);
            rd_req_r  <= (pick_s == REQ_RD);
            ref_req_r <= (pick_s == REQ_REF);
          end
        end
        REQ_REF, REQ_WR, REQ_RD: begin
          if (cmd_ack) begin
            state_r   <= IDLE;
            wr_req_r  <= 1'b0;
            rd_req_r  <= 1'b0;
            ref_req_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          wr_req_r  <= 1'b0;
          rd_req_r  <= 1'b0;
          ref_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign wr_req       = wr_req_r;
  assign rd_req       = rd_req_r;
  assign ref_req      = ref_req_r;
  assign ref_owed     = owed_r;
  assign ref_overflow = ovf_r;

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dram_cmd_scheduler
// Directed bench for dram_cmd_scheduler with TREFI_CYC=20, MAX_POSTPONE=8,
// DB_CYC=4. A behavioural model of the scheduling rules is compared against
// the DUT on every falling edge; literal expectations pin key scenarios.
// -----------------------------------------------------------------------------
module tb_dram_cmd_scheduler;

  localparam int TREFI = 20;
  localparam int MAXP  = 8;
  localparam int DBC   = 4;
`ifdef DRAM_SCHED_DEBOUNCE_EN
  localparam bit DEB   = 1'b1;
`else
  localparam bit DEB   = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       btn_write;
  logic       btn_read;
  logic       ctrl_ready;
  logic       cmd_ack;
  logic       wr_req;
  logic       rd_req;
  logic       ref_req;
  logic [3:0] ref_owed;
  logic       ref_overflow;

  dram_cmd_scheduler #(
    .TREFI_CYC    (TREFI),
    .MAX_POSTPONE (MAXP),
    .DB_CYC       (DBC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_write    (btn_write),
    .btn_read     (btn_read),
    .ctrl_ready   (ctrl_ready),
    .cmd_ack      (cmd_ack),
    .wr_req       (wr_req),
    .rd_req       (rd_req),
    .ref_req      (ref_req),
    .ref_owed     (ref_owed),
    .ref_overflow (ref_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int ack_mode = 0;  // 0: ack 3 cycles after request, 1: never ack, 2: ack ref on tick
  int seq_q[$];      // order of request rises: 1 ref, 2 write, 3 read

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Buttons: index 0 write, 1 read. Service: 0 none, 1 ref, 2 write, 3 read.
  int m_meta[2], m_sync[2], m_lvl[2], m_cnt[2], m_prev[2], m_pend[2];
  int m_tmr, m_owed, m_ovf, m_serv;

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_meta[b] = 0; m_sync[b] = 0; m_lvl[b] = 0;
      m_cnt[b] = 0;  m_prev[b] = 0; m_pend[b] = 0;
    end
    m_tmr = 0; m_owed = 0; m_ovf = 0; m_serv = 0;
  endtask

  task automatic model_step();
    int btn[2];
    int lvl_eff[2];
    int rise[2];
    int tick, acked, served, nxt, ack_ref;
    btn[0] = int'(btn_write);
    btn[1] = int'(btn_read);
    for (int b = 0; b < 2; b++) begin
      lvl_eff[b] = DEB ? m_lvl[b] : m_sync[b];
      rise[b]    = (lvl_eff[b] == 1 && m_prev[b] == 0) ? 1 : 0;
    end
    tick   = (m_tmr == TREFI - 1) ? 1 : 0;
    served = m_serv;
    acked  = (m_serv != 0 && cmd_ack) ? 1 : 0;
    nxt    = m_serv;
    if (m_serv == 0) begin
      if (ctrl_ready) begin
        if (m_owed == MAXP)                  nxt = 1;
        else if (m_pend[0] == 1 || rise[0] == 1) nxt = 2;
        else if (m_pend[1] == 1 || rise[1] == 1) nxt = 3;
        else if (m_owed > 0)                 nxt = 1;
        else                                 nxt = 0;
      end
    end else if (acked == 1) begin
      nxt = 0;
    end
    for (int b = 0; b < 2; b++) begin
      if (acked == 1 && served == 2 + b) m_pend[b] = 0;
      else if (rise[b] == 1)             m_pend[b] = 1;
    end
    ack_ref = (acked == 1 && served == 1) ? 1 : 0;
    if (tick == 1 && ack_ref == 0) begin
      if (m_owed == MAXP) m_ovf = 1;
      else                m_owed = m_owed + 1;
    end else if (ack_ref == 1 && tick == 0) begin
      m_owed = m_owed - 1;
    end
    m_tmr = (tick == 1) ? 0 : m_tmr + 1;
    for (int b = 0; b < 2; b++) begin
      if (m_sync[b] != m_lvl[b]) begin
        if (m_cnt[b] == DBC - 1) begin
          m_lvl[b] = m_sync[b];
          m_cnt[b] = 0;
        end else begin
          m_cnt[b] = m_cnt[b] + 1;
        end
      end else begin
        m_cnt[b] = 0;
      end
      m_prev[b] = lvl_eff[b];
      m_sync[b] = m_meta[b];
      m_meta[b] = btn[b];
    end
    m_serv = nxt;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------- per-cycle compare and request-order monitor ----------------
  initial begin
    int pw, pr, pf;
    pw = 0; pr = 0; pf = 0;
    forever begin
      @(negedge clk);
      chk("wr_req",       int'(wr_req),       (m_serv == 2) ? 1 : 0);
      chk("rd_req",       int'(rd_req),       (m_serv == 3) ? 1 : 0);
      chk("ref_req",      int'(ref_req),      (m_serv == 1) ? 1 : 0);
      chk("ref_owed",     int'(ref_owed),     m_owed);
      chk("ref_overflow", int'(ref_overflow), m_ovf);
      chk("onehot", ((int'(wr_req) + int'(rd_req) + int'(ref_req)) <= 1) ? 1 : 0, 1);
      if (ref_req && pf == 0) seq_q.push_back(1);
      if (wr_req  && pw == 0) seq_q.push_back(2);
      if (rd_req  && pr == 0) seq_q.push_back(3);
      pw = int'(wr_req); pr = int'(rd_req); pf = int'(ref_req);
    end
  end

  // ---------------- command acknowledge responder ----------------
  initial begin
    int cnt;
    cnt = 0;
    cmd_ack = 1'b0;
    forever begin
      @(negedge clk);
      case (ack_mode)
        0: begin
          if (cmd_ack) begin
            cmd_ack = 1'b0;
            cnt = 0;
          end else if (wr_req || rd_req || ref_req) begin
            cnt++;
            if (cnt == 3) cmd_ack = 1'b1;
          end else begin
            cnt = 0;
          end
        end
        1: begin
          cmd_ack = 1'b0;
          cnt = 0;
        end
        2: begin
          cmd_ack = ref_req && (m_tmr == TREFI - 1);
          cnt = 0;
        end
        default: cmd_ack = 1'b0;
      endcase
    end
  end

  // ---------------- helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int count_code(input int code);
    int n;
    n = 0;
    foreach (seq_q[i]) if (seq_q[i] == code) n++;
    return n;
  endfunction

  // Wait for an idle scheduler with nothing owed and the timer early in its interval
  task automatic wait_quiet(input string name, input int max_tmr);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (m_serv == 0 && m_owed == 0 && m_pend[0] == 0 && m_pend[1] == 0 &&
          m_tmr <= max_tmr) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for idle scheduler", name);
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int f[2];
    int nf;
    int lat;
    int hits;
    bit got;

    rst_n = 1'b0; btn_write = 1'b0; btn_read = 1'b0; ctrl_ready = 1'b0;
    cycles(3);
    chk("reset_wr_req", int'(wr_req), 0);
    chk("reset_rd_req", int'(rd_req), 0);
    chk("reset_ref_req", int'(ref_req), 0);
    chk("reset_ref_owed", int'(ref_owed), 0);
    chk("reset_ref_overflow", int'(ref_overflow), 0);
    rst_n = 1'b1;

    // 1: glitches then a sustained write press
    ctrl_ready = 1'b1;
    seq_q.delete();
    for (int g = 0; g < 3; g++) begin
      btn_write = 1'b1; cycles(1);
      btn_write = 1'b0; cycles(7);
    end
`ifdef DRAM_SCHED_DEBOUNCE_EN
    chk("t1_glitch_no_wr", count_code(2), 0);
`endif
    btn_write = 1'b1; cycles(10);
    btn_write = 1'b0; cycles(20);
`ifdef DRAM_SCHED_DEBOUNCE_EN
    chk("t1_one_wr", count_code(2), 1);
`endif

    // 2: write and read pressed together
    wait_quiet("t2_quiet", TREFI);
    seq_q.delete();
    btn_write = 1'b1; btn_read = 1'b1; cycles(10);
    btn_write = 1'b0; btn_read = 1'b0; cycles(40);
    f[0] = -1; f[1] = -1; nf = 0;
    foreach (seq_q[i]) begin
      if ((seq_q[i] == 2 || seq_q[i] == 3) && nf < 2) begin
        f[nf] = seq_q[i];
        nf++;
      end
    end
    chk("t2_first_is_wr", f[0], 2);
    chk("t2_second_is_rd", f[1], 3);

    // 3: controller busy for 200 cycles with a write pending
    wait_quiet("t3_quiet", 8);
    ctrl_ready = 1'b0;
    cycles(50);
    btn_write = 1'b1; cycles(10);
    btn_write = 1'b0; cycles(140);
    chk("t3_owed_sat", int'(ref_owed), 8);
    chk("t3_overflow", int'(ref_overflow), 1);
    seq_q.delete();
    ctrl_ready = 1'b1;
    cycles(20);
    chk("t3_first_ref", (seq_q.size() > 0) ? seq_q[0] : -1, 1);
    chk("t3_then_wr", (seq_q.size() > 1) ? seq_q[1] : -1, 2);
    cycles(150);

    // 4: refresh ack in the same cycle as a tick, owed = 3
    ctrl_ready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (m_owed == 3 && m_serv == 0) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL t4_setup timeout waiting for three owed refreshes");
    end
    ack_mode = 1;
    ctrl_ready = 1'b1;
    cycles(2);
    chk("t4_ref_req", int'(ref_req), 1);
    chk("t4_owed_before", int'(ref_owed), 3);
    ack_mode = 2;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (cmd_ack) begin got = 1'b1; break; end
    end
    @(negedge clk);
    ack_mode = 0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL t4_ack timeout waiting for tick-aligned ack");
    end
    chk("t4_owed_after", int'(ref_owed), 3);
    chk("t4_ref_dropped", int'(ref_req), 0);
    cycles(60);

    // 5: asynchronous reset while a read request is held
    wait_quiet("t5_quiet", 8);
    ack_mode = 1;
    btn_read = 1'b1; cycles(10);
    btn_read = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rd_req) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL t5_rd_req timeout waiting for read request");
    end
    cycles(50);
    chk("t5_pre_overflow", int'(ref_overflow), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rd_req_async", int'(rd_req), 0);
    chk("t5_owed_async", int'(ref_owed), 0);
    chk("t5_overflow_async", int'(ref_overflow), 0);
    cycles(2);
    rst_n = 1'b1;
    ack_mode = 0;
    hits = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (wr_req || rd_req) hits++;
    end
    chk("t5_no_req_after_release", hits, 0);

    // 6: read press latency
    wait_quiet("t6_quiet", 8);
    btn_read = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == (DEB ? 10 : 1)) btn_read = 1'b0;
      if (rd_req) begin lat = k; break; end
    end
    btn_read = 1'b0;
`ifdef DRAM_SCHED_DEBOUNCE_EN
    chk("t6_rd_latency", lat, 7);
`else
    chk("t6_rd_latency", lat, 3);
`endif
    cycles(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_cmd_scheduler.md
Name: dram_cmd_scheduler

Overview:
- Upstream stage of the DRAM state machine.
- Turns raw board buttons and a refresh-interval timer into one-hot, level-held command requests: write, read and refresh.
- The controller consumes each request and acknowledges it with a single-cycle pulse.
- Replaces the free-running refresh counter in the top level, and adds refresh postponement credits, debouncing and priority arbitration.

Parameters:
- TREFI_CYC, 2496: clk cycles per refresh interval (7.8 us at 320 MHz).
- MAX_POSTPONE, 8: maximum refreshes owed before a refresh becomes urgent.
- DB_CYC, 3200000: consecutive stable cycles needed to accept a button level change (10 ms at 320 MHz).

Ports:
- clk  in  1: 320 MHz controller clock.
- rst_n  in  1: asynchronous active-low reset.
- btn_write  in  1: raw asynchronous write button.
- btn_read  in  1: raw asynchronous read button.
- ctrl_ready  in  1: controller is in IDLE and can accept a command.
- cmd_ack  in  1: one-cycle pulse; the controller accepted the current request.
- wr_req  out  1: write request, held until acknowledged.
- rd_req  out  1: read request, held until acknowledged.
- ref_req  out  1: refresh request, held until acknowledged.
- ref_owed  out  4: count of refreshes owed.
- ref_overflow  out  1: sticky; a tick arrived while ref_owed == MAX_POSTPONE.

Behaviour:
- Reset (async, rst_n low): every output 0, all counters 0, debounced levels 0, FSM in IDLE. Reset mid-request drops the request immediately.
- Input path: each button goes through a 2-FF synchronizer.
- Debounce: a counter runs while the synchronized value differs from the debounced level and clears when they match. The debounced level flips when the counter reaches DB_CYC-1.
- Edge capture: a 0->1 edge of a debounced level sets wr_pend or rd_pend. An edge while the flag is already set is dropped; there is no queueing.
- Refresh timer: counts 0..TREFI_CYC-1 and wraps; the wrap cycle is the tick.
  - On a tick, ref_owed increments, saturating at MAX_POSTPONE.
  - A tick at saturation sets ref_overflow, which only reset clears.
- FSM states: IDLE, REQ_REF, REQ_WR, REQ_RD.
- IDLE with ctrl_ready=1 selects, first match wins:
  1. ref_owed == MAX_POSTPONE -> REQ_REF
  2. wr_pend -> REQ_WR
  3. rd_pend -> REQ_RD
  4. ref_owed > 0 -> REQ_REF
  5. otherwise stay in IDLE.
- IDLE with ctrl_ready=0 stays in IDLE.
- Outputs are registered and decoded from the state: a pending flag set in cycle N gives a request visible in cycle N+1 at the earliest.
- REQ_x holds its request high until cmd_ack=1, which is expected within 256 cycles. cmd_ack does not need ctrl_ready. On the ack:
  - REQ_WR clears wr_pend; REQ_RD clears rd_pend; REQ_REF decrements ref_owed.
  - The FSM returns to IDLE, and the request is low in the following cycle.
- Tick and refresh-ack in the same cycle: ref_owed is unchanged, and no overflow even at MAX_POSTPONE.
- cmd_ack while in IDLE is ignored.
- Invariant: at most one of wr_req, rd_req, ref_req is high in any cycle.
- Widths: ref_owed is 4 bits, so MAX_POSTPONE <= 15. Counter widths are $clog2 of their parameter.

Optional Feature:
- Macro: DRAM_SCHED_DEBOUNCE_EN.
- Defined: the debounce counter is present as described above.
- Undefined: the synchronizer output is used directly as the debounced level. This gives 2-cycle input latency and suits simulation.
- Arbitration, refresh and handshake behaviour are identical in both builds.

Decomposition:
- Shared package dram_ctrl_pkg holds:
  - the state enum (IDLE, REQ_REF, REQ_WR, REQ_RD);
  - default TREFI_CYC, MAX_POSTPONE and DB_CYC constants;
  - the ref_owed width constant.
- One sub-module, btn_sync_debounce: 2-FF synchronizer, debounce counter and rising-edge pulse. It is instantiated twice and carries the ifdef.

Test Plan (TREFI_CYC=20, DB_CYC=4, MAX_POSTPONE=8, ctrl_ready=1, ack 3 cycles after request unless stated):
1. btn_write high for 10 cycles with 1-cycle glitches before it -> only the sustained press yields one wr_req, which is held until cmd_ack and then low the next cycle. Glitches alone yield no request.
2. Write and read pressed in the same cycle, ref_owed=0 -> wr_req is served first, then rd_req. The two requests are never high together.
3. ctrl_ready=0 for 200 cycles -> ref_owed reaches 8 and then ref_overflow=1. After ctrl_ready rises with a write pending, ref_req is served before wr_req.
4. Refresh tick in the same cycle as the refresh cmd_ack, with ref_owed=3 -> ref_owed stays at 3.
5. rst_n pulsed low while rd_req is high -> rd_req, ref_owed and ref_overflow drop to 0 asynchronously, with no request after release until a new press.
6. Build without DRAM_SCHED_DEBOUNCE_EN: btn_read high for 1 cycle -> rd_req rises 3 cycles later.
